// File: rtl/rs_bank_aged_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_bank_aged_pkg
// Description : Shared types and constants for the banked, age-ordered
//               reservation station: uop record, FU enumeration, class-to-FU
//               mapping, ROB age helper and occupancy counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_bank_aged_pkg;

  localparam int PHYS_W            = 6;
  localparam int ROB_W             = 5;
  localparam int FU_NUM            = 3;
  localparam int RS_ENTRIES_PER_FU = 4;
  localparam int RS_OCC_W          = $clog2(RS_ENTRIES_PER_FU + 1);

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2
  } fu_e;

  typedef enum logic [1:0] {
    UC_ALU   = 2'd0,
    UC_MUL   = 2'd1,
    UC_LOAD  = 2'd2,
    UC_STORE = 2'd3
  } uop_class_e;

  typedef struct packed {
    uop_class_e        uop_class;
    logic [ROB_W-1:0]  rob_idx;
    logic [PHYS_W-1:0] pd;
    logic [PHYS_W-1:0] prs1;
    logic [PHYS_W-1:0] prs2;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              rdy1;
    logic              rdy2;
    logic [7:0]        tag;
  } rs_uop_t;

  function automatic fu_e uop_to_fu(input uop_class_e uc);
    case (uc)
      UC_ALU:  return FU_ALU;
      UC_MUL:  return FU_MUL;
      default: return FU_LSU;
    endcase
  endfunction

  // Distance from the ROB head; unsigned wrap gives the modulo for free.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx,
                                               input logic [ROB_W-1:0] head);
    return idx - head;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_bank_aged_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_bank_aged_if
// Description : Dispatch / wakeup / issue / recovery bundle of the reservation
//               station. master = dispatcher+FU side, slave = the RS.
//   disp_*     : dispatch request, ready and uop
//   wb_*       : WB_PORTS CDB wakeup ports
//   issue_*    : per-FU issue handshake and selected uop
//   flush/recover, rob_head_idx : squash control and age base
//   fu_occ, busy : per-bank occupancy, any-bank-full
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_bank_aged_if #(
  parameter int ENTRIES_PER_FU = rs_bank_aged_pkg::RS_ENTRIES_PER_FU,
  parameter int WB_PORTS       = 2
);
  import rs_bank_aged_pkg::*;

  localparam int OCC_W = $clog2(ENTRIES_PER_FU + 1);

  logic                               disp_valid;
  logic                               disp_ready;
  rs_uop_t                            disp_uop;
  logic [WB_PORTS-1:0]                wb_valid;
  logic [WB_PORTS-1:0][PHYS_W-1:0]    wb_pd;
  logic [FU_NUM-1:0]                  issue_valid;
  logic [FU_NUM-1:0]                  issue_ready;
  rs_uop_t [FU_NUM-1:0]               issue_uop;
  logic                               flush_valid;
  logic                               recover_valid;
  logic [ROB_W-1:0]                   recover_rob_idx;
  logic [ROB_W-1:0]                   rob_head_idx;
  logic [FU_NUM-1:0][OCC_W-1:0]       fu_occ;
  logic                               busy;

  modport master (
    output disp_valid, disp_uop, wb_valid, wb_pd, issue_ready,
           flush_valid, recover_valid, recover_rob_idx, rob_head_idx,
    input  disp_ready, issue_valid, issue_uop, fu_occ, busy
  );

  modport slave (
    input  disp_valid, disp_uop, wb_valid, wb_pd, issue_ready,
           flush_valid, recover_valid, recover_rob_idx, rob_head_idx,
    output disp_ready, issue_valid, issue_uop, fu_occ, busy
  );

endinterface
`default_nettype wire

// File: rtl/rs_bank_aged_age_select.sv
`default_nettype none
// ============================================================================
// Module      : rs_bank_aged_age_select
// Description : Age matrix of one RS bank plus oldest-ready picker.
//               age_q[i][j]=1 means slot i is older than slot j.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : clears the matrix
//   alloc, alloc_idx : slot written by dispatch this cycle
//   stay       : slots that remain valid across this edge
//   ready      : per-slot ready (valid and operands available)
//   sel, sel_any : one-hot oldest ready slot
// Revision    : 1.0 - initial release
// ============================================================================
module rs_bank_aged_age_select #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               alloc,
  input  logic [IDX_W-1:0]   alloc_idx,
  input  logic [ENTRIES-1:0] stay,
  input  logic [ENTRIES-1:0] ready,
  output logic [ENTRIES-1:0] sel,
  output logic               sel_any
);

  logic [ENTRIES-1:0][ENTRIES-1:0] age_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      age_q <= '0;
    end else if (alloc) begin
      // New entry is younger than everyone surviving; its own row is cleared.
      // The j==alloc_idx case resolves to 0 either way since that slot is free.
      for (int j = 0; j < ENTRIES; j++) begin
        age_q[alloc_idx][j] <= 1'b0;
        age_q[j][alloc_idx] <= stay[j];
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < ENTRIES; j++) begin
        if (ready[j] && age_q[j][i]) blocked = 1'b1;
      end
      sel[i] = ready[i] && !blocked;
    end
  end

  assign sel_any = |sel;

endmodule
`default_nettype wire

// File: rtl/rs_bank_aged.sv
`default_nettype none
// ============================================================================
// Module      : rs_bank_aged
// Description : Banked reservation station, one bank per FU, ENTRIES_PER_FU
//               slots per bank. Each bank issues its oldest ready uop; CDB
//               wakeup on WB_PORTS ports; recovery squashes younger entries.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : rs_bank_aged_if slave (dispatch, wakeup, issue, recovery,
//                occupancy)
// Optional    : RS_WAKEUP_BYPASS_EN - select also counts this cycle's CDB
//               matches, so a uop may issue in its wakeup cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_bank_aged
  import rs_bank_aged_pkg::*;
#(
  parameter int ENTRIES_PER_FU = RS_ENTRIES_PER_FU,
  parameter int WB_PORTS       = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  rs_bank_aged_if.slave bus
);

  localparam int E     = ENTRIES_PER_FU;
  localparam int IDX_W = $clog2(E);
  localparam int OCC_W = $clog2(E + 1);

  function automatic logic wb_hit(input logic [WB_PORTS-1:0]             v,
                                  input logic [WB_PORTS-1:0][PHYS_W-1:0] pd,
                                  input logic [PHYS_W-1:0]               prs);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (v[p] && (pd[p] == prs)) hit = 1'b1;
    end
    return hit;
  endfunction

  logic [1:0]        disp_fu;
  logic [FU_NUM-1:0] bank_free;
  logic [FU_NUM-1:0] bank_full;
  logic              disp_ok;
  rs_uop_t           disp_entry;

  assign disp_fu = uop_to_fu(bus.disp_uop.uop_class);
  assign disp_ok = bank_free[disp_fu] && !bus.flush_valid && !bus.recover_valid;
  assign bus.disp_ready = disp_ok;
  assign bus.busy       = |bank_full;

  // The dispatching uop sees the same-cycle CDB, so it never misses a wakeup.
  always_comb begin
    disp_entry      = bus.disp_uop;
    disp_entry.rdy1 = bus.disp_uop.rdy1 | wb_hit(bus.wb_valid, bus.wb_pd, bus.disp_uop.prs1);
    disp_entry.rdy2 = bus.disp_uop.rdy2 | wb_hit(bus.wb_valid, bus.wb_pd, bus.disp_uop.prs2);
  end

  for (genvar f = 0; f < FU_NUM; f++) begin : g_bank
    logic [E-1:0]      valid_q;
    rs_uop_t [E-1:0]   ent_q;
    rs_uop_t [E-1:0]   view;
    logic [E-1:0]      hit1, hit2, ready, squash, clr, stay, sel, alloc_vec;
    logic [IDX_W-1:0]  free_idx;
    logic              sel_any, alloc, issue_go, fire;
    rs_uop_t           sel_uop;

    always_comb begin
      view   = ent_q;
      hit1   = '0;
      hit2   = '0;
      ready  = '0;
      squash = '0;
      for (int i = 0; i < E; i++) begin
        hit1[i] = wb_hit(bus.wb_valid, bus.wb_pd, ent_q[i].prs1);
        hit2[i] = wb_hit(bus.wb_valid, bus.wb_pd, ent_q[i].prs2);
`ifdef RS_WAKEUP_BYPASS_EN
        view[i].rdy1 = ent_q[i].rdy1 | hit1[i];
        view[i].rdy2 = ent_q[i].rdy2 | hit2[i];
`endif
        ready[i] = valid_q[i] && (!view[i].uses_rs1 || view[i].rdy1)
                              && (!view[i].uses_rs2 || view[i].rdy2);
        squash[i] = bus.recover_valid && valid_q[i] &&
                    (rob_age(ent_q[i].rob_idx, bus.rob_head_idx) >
                     rob_age(bus.recover_rob_idx, bus.rob_head_idx));
      end
    end

    // Lowest-index slot free at the edge; slots freed this cycle wait a cycle.
    always_comb begin
      free_idx = '0;
      for (int i = E - 1; i >= 0; i--) begin
        if (!valid_q[i]) free_idx = IDX_W'(i);
      end
    end

    assign bank_free[f] = ~&valid_q;
    assign bank_full[f] = &valid_q;

    rs_bank_aged_age_select #(.ENTRIES(E), .IDX_W(IDX_W)) u_age (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush_valid),
      .alloc     (alloc),
      .alloc_idx (free_idx),
      .stay      (stay),
      .ready     (ready),
      .sel       (sel),
      .sel_any   (sel_any)
    );

    always_comb begin
      sel_uop = '0;
      for (int i = 0; i < E; i++) begin
        if (sel[i]) sel_uop = view[i];
      end
    end

    // A selected entry being squashed (or any flush) must not reach the FU.
    assign issue_go  = sel_any && !(|(sel & squash)) && !bus.flush_valid;
    assign fire      = issue_go && bus.issue_ready[f];
    assign clr       = (fire ? sel : '0) | squash;
    assign stay      = valid_q & ~clr;
    assign alloc     = bus.disp_valid && disp_ok && (disp_fu == 2'(f));
    assign alloc_vec = alloc ? (E'(1) << free_idx) : '0;

    assign bus.issue_valid[f] = issue_go;
    assign bus.issue_uop[f]   = issue_go ? sel_uop : '0;
    assign bus.fu_occ[f]      = OCC_W'($countones(valid_q));

    always_ff @(posedge clk) begin
      if (!rst_n || bus.flush_valid) begin
        valid_q <= '0;
      end else begin
        valid_q <= stay | alloc_vec;
      end
    end

    // Payload needs no reset; valid_q gates every use of it.
    always_ff @(posedge clk) begin
      for (int i = 0; i < E; i++) begin
        if (alloc && (free_idx == IDX_W'(i))) begin
          ent_q[i] <= disp_entry;
        end else begin
          if (hit1[i]) ent_q[i].rdy1 <= 1'b1;
          if (hit2[i]) ent_q[i].rdy2 <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
